mtl2_sysid_checker: RTL

Avalon-MM read master that is the initiator for the MTL2 system-ID slave. After reset, or on request, it reads the ID word (word address 0) and then the timestamp word (word address 1). It compares both against build-time expected values and reports pass/fail/timeout. It sits beside the Nios/painter subsystem in the MTL2 Qsys design and gates display bring-up on a matching hardware build.

---
 rtl/mtl2_sysid_pkg.sv | 21 ++
 rtl/mtl2_sysid_checker_if.sv | 18 +
 rtl/mtl2_sysid_timeout_ctr.sv | 23 ++
 rtl/mtl2_sysid_checker.sv | 105 ++++++++++
 4 files changed

// File: rtl/mtl2_sysid_pkg.sv
// Shared types and constants for the MTL2 system-ID checker.
package mtl2_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } sysid_state_t;

  // Word addresses inside the sysid slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Values of the hardware build this firmware was made for
  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1406873501;

endpackage

// File: rtl/mtl2_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
interface mtl2_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/mtl2_sysid_timeout_ctr.sv
// Per-transaction cycle counter; expired is high while the count sits at LIMIT-1,
// so the owner acts on the LIMIT-th busy cycle.
module mtl2_sysid_timeout_ctr #(
  parameter int LIMIT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  assign expired = (count == LAST);

  // Count busy cycles, hold at the limit, restart from zero on clear
  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable && !expired) count <= count + 16'd1;
  end
endmodule

// File: rtl/mtl2_sysid_checker.sv
// Reads sysid word 0 (ID) then word 1 (timestamp) and compares both against
// build-time values. Optional timeout: define MTL2_SYSID_CHECKER_TIMEOUT_EN.
module mtl2_sysid_checker
  import mtl2_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter int          TIMEOUT_CYCLES     = 1023,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  mtl2_sysid_checker_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);
  sysid_state_t state, state_nxt;
  logic first_cycle;
  logic req_st, wait_st, launch, expired, rdv;

  assign req_st  = (state == ST_ID_REQ)  || (state == ST_TS_REQ);
  assign wait_st = (state == ST_ID_WAIT) || (state == ST_TS_WAIT);
  assign rdv     = avm.avm_readdatavalid;
  assign launch  = (state == ST_IDLE) && (start || (AUTO_START && first_cycle));

`ifdef MTL2_SYSID_CHECKER_TIMEOUT_EN
  logic tmo_clear, tmo_en;
  assign tmo_en    = req_st || wait_st;
  // Held at zero outside a read, and restarted when the ID data lands so the
  // timestamp read gets its own full budget.
  assign tmo_clear = !tmo_en || (state == ST_ID_WAIT && rdv);

  mtl2_sysid_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Next-state: data beats the timeout in the *_WAIT states
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (launch) state_nxt = ST_ID_REQ;
      ST_ID_REQ:  if (expired) state_nxt = ST_FIN;
                  else if (!avm.avm_waitrequest) state_nxt = ST_ID_WAIT;
      ST_ID_WAIT: if (rdv) state_nxt = ST_TS_REQ;
                  else if (expired) state_nxt = ST_FIN;
      ST_TS_REQ:  if (expired) state_nxt = ST_FIN;
                  else if (!avm.avm_waitrequest) state_nxt = ST_TS_WAIT;
      ST_TS_WAIT: if (rdv || expired) state_nxt = ST_FIN;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, captured words and sticky result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      first_cycle <= 1'b1;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nxt;
      first_cycle <= 1'b0;
      if (launch) begin
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end
      if (state == ST_ID_WAIT && rdv) begin
        id_value <= avm.avm_readdata;
        id_ok    <= (avm.avm_readdata == EXPECTED_ID);
      end
      if (state == ST_TS_WAIT && rdv) begin
        ts_value <= avm.avm_readdata;
        ts_ok    <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (expired && (req_st || (wait_st && !rdv))) timeout <= 1'b1;
    end
  end

  // Bus and status are pure state decodes, so they are stable through stalls
  assign avm.avm_read    = req_st;
  assign avm.avm_address = (state == ST_TS_REQ || state == ST_TS_WAIT) ? SYSID_ADDR_TS
                                                                        : SYSID_ADDR_ID;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);
endmodule
